hysteresis_tracking: RTL

// - Final Canny stage, directly downstream of double thresholding: edge tracking by hysteresis.
// - Consumes a raster pixel stream of strong/weak maps. Emits a binary edge map.
// - A weak pixel survives only if any of its 8 neighbours is strong. Single pass, no iteration.
// - Uses two line buffers, so there is no full-frame storage.

---
 rtl/hysteresis_tracking_pkg.sv | 33 +++
 rtl/hysteresis_tracking_if.sv | 24 ++
 rtl/hysteresis_tracking_line_buffer.sv | 26 ++
 rtl/hysteresis_tracking.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hysteresis_tracking_pkg.sv
// Shared types and constants for the Canny hysteresis tracking stage.
// Pixel classes, output levels and FSM state encodings.
package canny_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } pix_class_t;

    localparam logic [7:0] EDGE_ON  = 8'd255;
    localparam logic [7:0] WEAK_VAL = 8'd128;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t FILL   = 2'd1;
    localparam state_t STREAM = 2'd2;
    localparam state_t FLUSH  = 2'd3;

    // A pixel set in both maps counts as strong.
    function automatic pix_class_t classify(input logic [7:0] str_pix, input logic [7:0] weak_pix);
        pix_class_t cls;
        if (str_pix != 8'd0) begin
            cls = CLS_STRONG;
        end else if (weak_pix != 8'd0) begin
            cls = CLS_WEAK;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/hysteresis_tracking_if.sv
// Pixel stream bundle: strong/weak maps in, binary edge map out.
// The source/sink side uses master, the tracking block uses slave.
interface hysteresis_tracking_if;

    logic       in_val;
    logic       in_rdy;
    logic       in_sof;
    logic [7:0] str_pix;
    logic [7:0] weak_pix;
    logic       edge_val;
    logic [7:0] edge_pix;
    logic       frame_done;

    modport master (
        output in_val, in_sof, str_pix, weak_pix,
        input  in_rdy, edge_val, edge_pix, frame_done
    );

    modport slave (
        input  in_val, in_sof, str_pix, weak_pix,
        output in_rdy, edge_val, edge_pix, frame_done
    );

endinterface

// File: rtl/hysteresis_tracking_line_buffer.sv
// Shift-on-enable delay line of DEPTH entries; dout is the entry written DEPTH shifts ago.
// Storage has no reset: stale contents are masked by the consumer.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/hysteresis_tracking.sv
// Canny edge tracking by hysteresis: a weak pixel survives only next to a strong one.
// Two line buffers feed a 3x3 class window; the final W+1 outputs are drained with NONE pixels.
//   state  | meaning
//   IDLE   | wait for an in_sof transfer, drop everything else
//   FILL   | prime line buffers with the first W+1 pixels, no output
//   STREAM | one output per input transfer
//   FLUSH  | inject W+1 NONE pixels to drain the window, then frame_done
module hysteresis_tracking
    import canny_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIX_WIDTH    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hysteresis_tracking_if.slave bus
);

    localparam int PW = PIX_WIDTH / 3;
    localparam int CW = $clog2(FRAME_WIDTH) + 1;
    localparam int RW = $clog2(FRAME_HEIGHT) + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_t        state, state_nxt;
    logic          in_rdy_q;
    logic [CW-1:0] in_col, out_col, w_col;
    logic [RW-1:0] in_row, out_row, w_row;
    logic          xfer, sof_xfer, shift, emit;
    logic          in_last, out_last;
    pix_class_t    cls_new;
    logic [1:0]    lb0_q, lb1_q;
    pix_class_t    win_t [3];
    pix_class_t    win_m [3];
    pix_class_t    win_b [3];
    logic          w_vld, w_last;
    logic [2:0]    col_en;
    logic          nb_strong, edge_on;
    logic          edge_val_q, edge_last_q, frame_done_q;
    logic [PW-1:0] edge_pix_q;

    assign xfer     = bus.in_val && in_rdy_q;
    assign sof_xfer = xfer && bus.in_sof;
    assign in_last  = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign out_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        emit      = 1'b0;
        cls_new   = classify(bus.str_pix, bus.weak_pix);
        case (state)
            IDLE: begin
                if (sof_xfer) begin
                    shift     = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    shift = 1'b1;
                    if (!bus.in_sof && in_row == ROW_ONE && in_col == '0) begin
                        state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    shift = 1'b1;
                    if (bus.in_sof) begin
                        state_nxt = FILL;
                    end else begin
                        emit = 1'b1;
                        if (in_last) begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                shift   = 1'b1;
                emit    = 1'b1;
                cls_new = CLS_NONE;
                if (out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    line_buffer #(.DEPTH(FRAME_WIDTH), .WIDTH(2)) u_lb0 (
        .clk  (clk),
        .en   (shift),
        .din  (cls_new),
        .dout (lb0_q)
    );

    line_buffer #(.DEPTH(FRAME_WIDTH), .WIDTH(2)) u_lb1 (
        .clk  (clk),
        .en   (shift),
        .din  (lb0_q),
        .dout (lb1_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_rdy_q <= 1'b0;
            in_col   <= '0;
            in_row   <= '0;
            out_col  <= '0;
            out_row  <= '0;
        end else begin
            state    <= state_nxt;
            in_rdy_q <= (state_nxt != FLUSH);
            if (sof_xfer) begin
                in_col  <= COL_ONE;
                in_row  <= '0;
                out_col <= '0;
                out_row <= '0;
            end else begin
                if (xfer && state != IDLE) begin
                    if (in_col == COL_LAST) begin
                        in_col <= '0;
                        in_row <= in_row + ROW_ONE;
                    end else begin
                        in_col <= in_col + COL_ONE;
                    end
                end
                if (emit) begin
                    if (out_last) begin
                        out_col <= '0;
                        out_row <= '0;
                    end else if (out_col == COL_LAST) begin
                        out_col <= '0;
                        out_row <= out_row + ROW_ONE;
                    end else begin
                        out_col <= out_col + COL_ONE;
                    end
                end
            end
        end
    end

    // Window column 2 is the newest; the centre is always column 1, middle row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                win_t[i] <= CLS_NONE;
                win_m[i] <= CLS_NONE;
                win_b[i] <= CLS_NONE;
            end
            w_col  <= '0;
            w_row  <= '0;
            w_vld  <= 1'b0;
            w_last <= 1'b0;
        end else begin
            if (shift) begin
                for (int i = 0; i < 2; i++) begin
                    win_t[i] <= win_t[i+1];
                    win_m[i] <= win_m[i+1];
                    win_b[i] <= win_b[i+1];
                end
                win_t[2] <= pix_class_t'(lb1_q);
                win_m[2] <= pix_class_t'(lb0_q);
                win_b[2] <= cls_new;
                w_col    <= out_col;
                w_row    <= out_row;
            end
            w_vld  <= emit;
            w_last <= emit && out_last && (state == FLUSH);
        end
    end

    // Row/column masking keeps line-wrap and stale line-buffer data out of the window.
    always_comb begin
        col_en    = {w_col != COL_LAST, 1'b1, w_col != '0};
        nb_strong = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (col_en[c]) begin
                if (w_row != '0 && win_t[c] == CLS_STRONG) nb_strong = 1'b1;
                if (w_row != ROW_LAST && win_b[c] == CLS_STRONG) nb_strong = 1'b1;
                if (c != 1 && win_m[c] == CLS_STRONG) nb_strong = 1'b1;
            end
        end
        edge_on = (win_m[1] == CLS_STRONG) || ((win_m[1] == CLS_WEAK) && nb_strong);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_val_q   <= 1'b0;
            edge_pix_q   <= '0;
            edge_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            edge_val_q   <= w_vld;
            edge_pix_q   <= (w_vld && edge_on) ? PW'(EDGE_ON) : '0;
            edge_last_q  <= w_last;
            frame_done_q <= edge_last_q;
        end
    end

    assign bus.in_rdy     = in_rdy_q;
    assign bus.edge_val   = edge_val_q;
    assign bus.edge_pix   = edge_pix_q;
    assign bus.frame_done = frame_done_q;

endmodule
